// File: rtl/rgb_depth_renderer.sv
// rgb_depth_renderer
//   Renders the three 3-bit channel levels of the rgbDepth bus onto 1-bit
//   VGA colour pins. PWM dithering turns each level into a proportional
//   on-ratio of pixels. The levels are shadowed once per frame, so a level
//   change never tears mid-frame.
//
// Parameters
//   DITHER_EN    1: PWM dithering; 0: threshold mode (on iff level >= 4)
//   FRAME_ROTATE 1: advance the dither phase by one each frame; 0: fixed at 0
//
// Ports
//   clock        pixel clock, rising edge
//   reset        synchronous, active-high
//   rgbDepth     live levels: [2:0] red, [5:3] green, [8:6] blue
//   videoOn      high during the active display area
//   frameStart   single-cycle pulse at the start of vertical blanking
//   red/green/blue  registered colour pins (1 clock latency)
//   depthLatched shadow copy of the levels currently being rendered
module rgb_depth_renderer #(
  parameter int DITHER_EN    = 1,
  parameter int FRAME_ROTATE = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [8:0] rgbDepth,
  input  logic       videoOn,
  input  logic       frameStart,
  output logic       red,
  output logic       green,
  output logic       blue,
  output logic [8:0] depthLatched
);

  logic [2:0] pPhase;
  logic [2:0] fPhase;
  logic [2:0] dIndex;

  // 3-bit add, carry discarded: wraps mod 8.
  always_comb dIndex = pPhase + fPhase;

  function automatic logic chanOn(input logic [2:0] level, input logic [2:0] idx);
    if (DITHER_EN != 0) return (level == 3'd7) || (level > idx);
    else                return level[2];
  endfunction

  // The pixel is computed from pre-update state, so a frameStart that
  // coincides with videoOn still renders with the old shadow and phases.
  always_ff @(posedge clock) begin
    if (reset) begin
      red          <= 1'b0;
      green        <= 1'b0;
      blue         <= 1'b0;
      depthLatched <= '0;
      pPhase       <= '0;
      fPhase       <= '0;
    end else begin
      red   <= videoOn && chanOn(depthLatched[2:0], dIndex);
      green <= videoOn && chanOn(depthLatched[5:3], dIndex);
      blue  <= videoOn && chanOn(depthLatched[8:6], dIndex);
      if (frameStart) begin
        depthLatched <= rgbDepth;
        pPhase       <= '0;
        fPhase       <= (FRAME_ROTATE != 0) ? fPhase + 3'd1 : '0;
      end else if (videoOn) begin
        pPhase <= pPhase + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_rgb_depth_renderer.sv
module tb_rgb_depth_renderer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [8:0] rgbDepth = '0;
  logic       videoOn = 1'b0;
  logic       frameStart = 1'b0;

  // Three configurations: 0 = dither+rotate, 1 = dither fixed phase, 2 = threshold.
  logic       r0, g0, b0, r1, g1, b1, r2, g2, b2;
  logic [8:0] dl0, dl1, dl2;
  logic [2:0] dutRgb [3];
  logic [8:0] dutLatch [3];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rgb_depth_renderer #(.DITHER_EN(1), .FRAME_ROTATE(1)) dutA (
    .clock(clock), .reset(reset), .rgbDepth(rgbDepth), .videoOn(videoOn),
    .frameStart(frameStart), .red(r0), .green(g0), .blue(b0), .depthLatched(dl0));
  rgb_depth_renderer #(.DITHER_EN(1), .FRAME_ROTATE(0)) dutB (
    .clock(clock), .reset(reset), .rgbDepth(rgbDepth), .videoOn(videoOn),
    .frameStart(frameStart), .red(r1), .green(g1), .blue(b1), .depthLatched(dl1));
  rgb_depth_renderer #(.DITHER_EN(0), .FRAME_ROTATE(1)) dutC (
    .clock(clock), .reset(reset), .rgbDepth(rgbDepth), .videoOn(videoOn),
    .frameStart(frameStart), .red(r2), .green(g2), .blue(b2), .depthLatched(dl2));

  assign dutRgb[0] = {r0, g0, b0};
  assign dutRgb[1] = {r1, g1, b1};
  assign dutRgb[2] = {r2, g2, b2};
  assign dutLatch[0] = dl0;
  assign dutLatch[1] = dl1;
  assign dutLatch[2] = dl2;

  // Reference model: pixel count within the line, frame count, shadow levels.
  int         mPix [3];
  int         mFrame [3];
  logic [8:0] mLatch [3];
  logic [2:0] expRgb [3];
  logic [8:0] expLatch [3];
  int         pixIdx;   // active pixels since the last frameStart

  function automatic logic refOn(input int cfg, input int level, input int pix, input int frame);
    int d;
    if (cfg == 2) return level >= 4;
    d = (pix + frame) % 8;
    // Level k lights k of every 8 dither slots; 7 lights all of them.
    return (level == 7) || (d < level);
  endfunction

  task automatic tick(input logic rst, input logic fs, input logic vo, input logic [8:0] depth);
    reset = rst; frameStart = fs; videoOn = vo; rgbDepth = depth;
    @(posedge clock);
    for (int c = 0; c < 3; c++) begin
      if (rst) begin
        expRgb[c] = '0; mLatch[c] = '0; mPix[c] = 0; mFrame[c] = 0;
      end else begin
        expRgb[c][2] = vo && refOn(c, int'(mLatch[c][2:0]), mPix[c], mFrame[c]);
        expRgb[c][1] = vo && refOn(c, int'(mLatch[c][5:3]), mPix[c], mFrame[c]);
        expRgb[c][0] = vo && refOn(c, int'(mLatch[c][8:6]), mPix[c], mFrame[c]);
        if (fs) begin
          mLatch[c] = depth;
          mPix[c] = 0;
          mFrame[c] = (c == 1) ? 0 : (mFrame[c] + 1) % 8;
        end else if (vo) begin
          mPix[c] = (mPix[c] + 1) % 8;
        end
      end
      expLatch[c] = mLatch[c];
    end
    if (rst || fs) pixIdx = 0; else if (vo) pixIdx++;
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 1, 9'h1FF);
    tick(1, 0, 1, 9'h1FF);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (dutRgb[c] !== 3'b000 || dutLatch[c] !== 9'h000) begin
        errors++;
        $display("FAIL reset cfg%0d: rgb=%b latch=%h, required rgb=000 latch=000", c, dutRgb[c], dutLatch[c]);
      end
    end
    tick(0, 1, 0, 9'h1FF);
    checks++;
    if (dl0 !== 9'h1FF) begin
      errors++;
      $display("FAIL reset_latch: latch=%h, required 1ff", dl0);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, 9'h000);
      checks++;
      if (dutRgb[0] !== 3'b111) begin
        errors++;
        $display("FAIL full_level pix%0d: rgb=%b, required 111", i, dutRgb[0]);
      end
    end
  endtask

  task automatic test_fixed_phase();
    logic [7:0] redSeq;
    redSeq = 8'b0000_0111;  // bit i = red at pixel i for level 3
    tick(1, 0, 0, 9'h000);
    tick(0, 1, 0, 9'b000_000_011);
    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 1, 9'h000);
      checks++;
      if (dutRgb[1] !== {redSeq[i % 8], 2'b00} || dutRgb[1] !== expRgb[1]) begin
        errors++;
        $display("FAIL fixed_phase pix%0d: rgb=%b, required %b", i, dutRgb[1], {redSeq[i % 8], 2'b00});
      end
    end
  endtask

  task automatic test_rotate();
    tick(1, 0, 0, 9'h000);
    for (int f = 1; f <= 2; f++) begin
      tick(0, 1, 0, 9'b000_000_001);
      tick(0, 0, 0, 9'h000);
      for (int i = 0; i < 8; i++) begin
        tick(0, 0, 1, 9'h000);
        checks++;
        if (r0 !== (i == 8 - f) || dutRgb[0] !== expRgb[0]) begin
          errors++;
          $display("FAIL rotate frame%0d pix%0d: red=%b, required %b", f, i, r0, (i == 8 - f));
        end
      end
    end
  endtask

  task automatic test_no_tear();
    tick(1, 0, 0, 9'h000);
    tick(0, 1, 0, 9'h000);
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 1, (i < 2) ? 9'h000 : 9'h1FF);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dutRgb[c] !== 3'b000 || dutLatch[c] !== 9'h000) begin
          errors++;
          $display("FAIL no_tear cfg%0d pix%0d: rgb=%b latch=%h, required 000/000", c, i, dutRgb[c], dutLatch[c]);
        end
      end
    end
    tick(0, 1, 0, 9'h1FF);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, 9'h000);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dutRgb[c] !== 3'b111) begin
          errors++;
          $display("FAIL after_latch cfg%0d pix%0d: rgb=%b, required 111", c, i, dutRgb[c]);
        end
      end
    end
  endtask

  task automatic test_collision();
    tick(1, 0, 0, 9'h000);
    tick(0, 1, 0, 9'h007);
    tick(0, 0, 1, 9'h000);
    tick(0, 0, 1, 9'h000);
    tick(0, 1, 1, 9'h000);
    checks++;
    if (r0 !== 1'b1 || dl0 !== 9'h000) begin
      errors++;
      $display("FAIL collision_pixel: red=%b latch=%h, required red=1 latch=000", r0, dl0);
    end
    tick(0, 0, 1, 9'h000);
    checks++;
    if (r0 !== 1'b0) begin
      errors++;
      $display("FAIL collision_next: red=%b, required 0", r0);
    end
    // Observe the pPhase restart through a level-3 red on the fixed-phase instance.
    tick(0, 0, 1, 9'h003);
    tick(0, 1, 1, 9'h003);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, 9'h000);
      checks++;
      if (r1 !== (i < 3)) begin
        errors++;
        $display("FAIL collision_restart pix%0d: red=%b, required %b", i, r1, (i < 3));
      end
    end
  endtask

  task automatic test_threshold();
    tick(1, 0, 0, 9'h000);
    tick(0, 1, 0, 9'b111_100_011);
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, 9'h000);
      checks++;
      if (dutRgb[2] !== 3'b011) begin
        errors++;
        $display("FAIL threshold pix%0d: rgb=%b, required 011", i, dutRgb[2]);
      end
    end
    tick(0, 0, 0, 9'h000);
    checks++;
    if (dutRgb[2] !== 3'b000) begin
      errors++;
      $display("FAIL threshold_blank: rgb=%b, required 000", dutRgb[2]);
    end
  endtask

  task automatic test_random();
    logic fs, vo, rst;
    tick(1, 0, 0, 9'h000);
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      fs  = ($urandom_range(0, 24) == 0);
      vo  = ($urandom_range(0, 3) != 0);
      tick(rst, fs, vo, 9'($urandom));
      for (int c = 0; c < 3; c++) begin
        checks++;
        if (dutRgb[c] !== expRgb[c] || dutLatch[c] !== expLatch[c]) begin
          errors++;
          $display("FAIL random cfg%0d step%0d: rgb=%b latch=%h, required rgb=%b latch=%h",
                   c, n, dutRgb[c], dutLatch[c], expRgb[c], expLatch[c]);
        end
      end
    end
  endtask

  initial begin
    pixIdx = 0;
    test_reset();
    test_fixed_phase();
    test_rotate();
    test_no_tear();
    test_collision();
    test_threshold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
